// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-indexed data memory.
// Latency from accept: word store 2, load 3, sub-word store 4, rejected request 1.
// Backpressure: Ready is high only in IDLE, so one request is in flight at a time.
//
// Ports:
//   Clk, Reset                        clock, synchronous active-high reset
//   Req/Ready                         request handshake (accept on Req && Ready)
//   Store, Size, Unsigned, Addr,
//   StoreData                         request fields, captured at accept
//   LoadResult, Done, Err             completion results
//   MemAddress, MemWriteData,
//   MemRead, MemWrite, MemReadData    word-indexed memory port
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  output logic        Ready,
  input  logic        Store,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic [31:0] LoadResult,
  output logic        Done,
  output logic        Err,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemReadData
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_ERR} state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  state_t      state, next_state;
  logic        accept;
  logic        bad_req;
  logic        word_store;
  logic        store_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [15:0] sdata_q;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Ready is a registered copy of (state == S_IDLE), so it is a valid accept qualifier.
  assign accept     = Req && Ready;
  assign word_store = Store && (Size == 2'b10);

  // Request legality, judged on the live inputs at the accept edge.
  always_comb begin
    bad_req = 1'b0;
    case (Size)
      2'b00:   bad_req = 1'b0;
      2'b01:   bad_req = Addr[0];
      2'b10:   bad_req = (Addr[1:0] != 2'b00);
      default: bad_req = 1'b1;
    endcase
    if ({2'b00, Addr[31:2]} >= MEM_LIMIT) bad_req = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad_req)         next_state = S_ERR;
          else if (word_store) next_state = S_WR;
          else                 next_state = S_RD;
        end
      end
      S_RD:    next_state = S_WAIT;
      S_WAIT:  next_state = store_q ? S_WR : S_IDLE;
      S_WR:    next_state = S_IDLE;
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores (little-endian).
  always_comb begin
    rd_byte = MemReadData[{lane_q, 3'b000} +: 8];
    rd_half = MemReadData[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_ext = MemReadData;
    endcase
    merged = MemReadData;
    if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8]      = sdata_q[7:0];
    else                 merged[{lane_q[1], 4'b0000} +: 16] = sdata_q[15:0];
  end

  // All outputs are flops; strobes are decoded from next_state so they line up
  // with the state they belong to.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Ready        <= 1'b1;
      Done         <= 1'b0;
      Err          <= 1'b0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      LoadResult   <= '0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      store_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
      sdata_q      <= '0;
    end else begin
      Ready    <= (next_state == S_IDLE);
      MemRead  <= (next_state == S_RD);
      MemWrite <= (next_state == S_WR);
      Err      <= (next_state == S_ERR);
      Done     <= (next_state == S_ERR) || (state == S_WR) ||
                  ((state == S_WAIT) && !store_q);

      if (accept) begin
        store_q <= Store;
        size_q  <= Size;
        uns_q   <= Unsigned;
        lane_q  <= Addr[1:0];
        sdata_q <= StoreData[15:0];
      end

      // Rejected requests leave the memory-side registers untouched.
      if (accept && !bad_req) begin
        MemAddress <= {2'b00, Addr[31:2]};
        if (word_store) MemWriteData <= StoreData;
      end

      if (state == S_WAIT) begin
        if (store_q) MemWriteData <= merged;
        else         LoadResult   <= load_ext;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage front end that sits directly upstream of the word-indexed data memory.
- Accepts byte-addressed load/store requests of byte, halfword or word size from the pipeline.
- Converts each request into word-indexed MemRead/MemWrite accesses, using read-modify-write for sub-word stores.
- Returns loaded data that is lane-extracted and sign- or zero-extended.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in the downstream memory; word indices >= MEM_WORDS are out of range.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous active-high reset.
- Req  in  1  request valid; accepted when Req && Ready.
- Ready  out  1  high only in IDLE.
- Store  in  1  1 = store, 0 = load.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- Unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- Addr  in  32  byte address.
- StoreData  in  32  store data, right-justified.
- LoadResult  out  32  extended load data; holds until the next successful load.
- Done  out  1  one-cycle pulse at completion of every accepted request.
- Err  out  1  one-cycle pulse coincident with Done for a rejected request.
- MemAddress  out  32  word index = {2'b0, Addr[31:2]}.
- MemWriteData  out  32  word to write.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemReadData  in  32  memory read data, valid the cycle after MemRead is sampled.

Behaviour:
- Reset: state IDLE; Ready=1; all other outputs 0.
- Reset mid-operation aborts the request: no Done, no Err, MemRead/MemWrite low next cycle, no deferred write.
- Clock and reset are a single Clk; Reset is synchronous, active-high.
- All outputs are registered. MemRead and MemWrite are never high together.
- Request fields are captured at the accept edge; inputs are don't-care afterwards.
- Little-endian lane mapping:
  - byte k = Addr[1:0] occupies bits [8k+7:8k].
  - halfword h = Addr[1] occupies bits [16h+15:16h].
- Rejection checks, evaluated at accept; on any failure there is no memory access and Err=Done=1 the next cycle, then IDLE:
  - Size=11.
  - Halfword with Addr[0]=1.
  - Word with Addr[1:0]!=0.
  - Addr[31:2] >= MEM_WORDS.
- States:
  - IDLE: Ready=1. On accept:
    - load or sub-word store → RD.
    - word store → WR with MemWriteData=StoreData.
    - rejected → ERR.
  - RD: MemRead=1 for exactly one cycle → WAIT.
  - WAIT: MemReadData valid.
    - Load: LoadResult <= extended lane; Done=1 next cycle; → IDLE.
    - Sub-word store: MemWriteData <= MemReadData with the addressed lane replaced by StoreData[7:0] or [15:0]; → WR.
  - WR: MemWrite=1 for exactly one cycle; Done=1 next cycle; → IDLE.
  - ERR: Done=1, Err=1; → IDLE.
- Latency, counting from the accept edge to the Done cycle:
  - Load: 3 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 4 cycles.
  - Rejected request: 1 cycle.
- Ready returns high in the same cycle as Done, so back-to-back requests are allowed. A request accepted in the Done cycle starts normally.
- Extension:
  - Byte: Unsigned ? {24'b0,b} : {{24{b[7]}},b}.
  - Halfword: analogous with 16 bits.
  - Word: passed through; Unsigned is ignored.
- Between accesses, MemAddress and MemWriteData hold their last values.

Test Plan:
- Word store then load: store Addr=0x0C, data 0xDEADBEEF → MemWrite pulses 1 cycle with MemAddress=3 and Done 2 cycles after accept. Load word 0x0C → LoadResult=0xDEADBEEF with Done 3 cycles after accept.
- Byte store RMW: word 3 = 0x11223344; store byte Addr=0x0E, data 0xAB → MemRead then MemWrite of 0x11AB3344. Done at cycle 4. MemRead and MemWrite are never simultaneous.
- Sign/zero extension: word 3 = 0x80FF7F01.
  - Load byte 0x0E signed → 0xFFFFFFFF.
  - Load byte 0x0F unsigned → 0x00000080.
  - Load half 0x0C signed → 0x00007F01.
  - Load half 0x0E signed → 0xFFFF80FF.
- Rejections: each of the following gives Err=Done=1 one cycle after accept, no MemRead/MemWrite, and LoadResult unchanged:
  - half load at 0x01.
  - word store at 0x06.
  - Size=11.
  - word load at 0x80 (index 32 with MEM_WORDS=32).
- Reset mid-RMW: assert Reset during the WAIT of a byte store → MemWrite never asserted, memory word unchanged, Ready=1 and all outputs 0 after the reset edge.
- Back-to-back: hold Req high for a load followed by a word store → the second request is accepted in the first request's Done cycle. Done pulses are separate, one per request.
